si_header_parser: RTL and testbench



---
 rtl/si_header_pkg.sv | 16 +
 rtl/si_axis_reg_slice.sv | 39 +++
 rtl/si_header_parser.sv | 91 +++++++++
 tb/tb_si_header_parser.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/si_header_pkg.sv
// si_header_pkg: header field layout, default header constants and parser states
package si_header_pkg;

    localparam logic [31:0] HDR_MAGIC_DEFAULT   = 32'h5349_5454;
    localparam logic [7:0]  HDR_VERSION_DEFAULT = 8'h01;

    localparam int MAGIC_LSB   = 0;
    localparam int MAGIC_W     = 32;
    localparam int VERSION_LSB = 32;
    localparam int VERSION_W   = 8;
    localparam int SEQ_LSB     = 64;
    localparam int SEQ_W       = 32;

    typedef enum logic [1:0] {HEADER, FORWARD, DROP} parser_state_t;

endpackage

// File: rtl/si_axis_reg_slice.sv
// si_axis_reg_slice: single-stage AXI-stream register, full throughput, registered outputs
module si_axis_reg_slice #(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8
) (
    input  logic                  eth_clk,
    input  logic                  eth_rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [KEEP_WIDTH-1:0] s_keep,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [KEEP_WIDTH-1:0] m_keep,
    output logic                  m_last
);

    assign s_ready = !m_valid || m_ready;

    // load a new beat whenever the slot is empty or draining; otherwise hold
    always_ff @(posedge eth_clk or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end else if (s_ready) begin
            m_valid <= s_valid;
            if (s_valid) begin
                m_data <= s_data;
                m_keep <= s_keep;
                m_last <= s_last;
            end
        end
    end

endmodule

// File: rtl/si_header_parser.sv
// si_header_parser: checks the per-packet header, tracks sequence numbers, forwards valid payloads
module si_header_parser
    import si_header_pkg::*;
#(
    parameter int          DATA_WIDTH  = 128,
    parameter int          KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter logic [31:0] HDR_MAGIC   = HDR_MAGIC_DEFAULT,
    parameter logic [7:0]  HDR_VERSION = HDR_VERSION_DEFAULT
) (
    input  logic                  eth_clk,
    input  logic                  eth_rst_n,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  lost_packet,
    output logic                  invalid_packet
);

    parser_state_t    state, state_nxt;
    logic             slice_ready, fwd_valid, accept, hdr_valid, seq_valid;
    logic [SEQ_W-1:0] seq, expected_seq;

    assign seq       = s_axis_tdata[SEQ_LSB +: SEQ_W];
    assign hdr_valid = s_axis_tdata[MAGIC_LSB +: MAGIC_W] == HDR_MAGIC
                    && s_axis_tdata[VERSION_LSB +: VERSION_W] == HDR_VERSION
                    && &s_axis_tkeep && !s_axis_tlast;
    assign accept    = s_axis_tvalid && s_axis_tready;

    // state register
    always_ff @(posedge eth_clk or negedge eth_rst_n) begin
        if (!eth_rst_n) state <= HEADER;
        else            state <= state_nxt;
    end

    // next state: every packet ends in HEADER on its tlast beat
    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = state == HEADER ? (hdr_valid ? FORWARD : (s_axis_tlast ? HEADER : DROP))
                                        : (s_axis_tlast ? HEADER : state);
    end

    // outputs: DROP sinks beats freely, only FORWARD feeds the output slice
    always_comb begin
        s_axis_tready  = state == DROP ? 1'b1 : slice_ready;
        fwd_valid      = s_axis_tvalid && state == FORWARD;
        invalid_packet = state == DROP || (state == HEADER && !hdr_valid);
    end

    // sequence tracking on each accepted valid header; gap reported the following cycle
    always_ff @(posedge eth_clk or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            seq_valid    <= 1'b0;
            expected_seq <= '0;
            lost_packet  <= 1'b0;
        end else begin
            lost_packet <= 1'b0;
            if (accept && state == HEADER && hdr_valid) begin
                lost_packet  <= seq_valid && seq != expected_seq;
                expected_seq <= seq + 1'b1;
                seq_valid    <= 1'b1;
            end
        end
    end

    si_axis_reg_slice #(
        .DATA_WIDTH(DATA_WIDTH),
        .KEEP_WIDTH(KEEP_WIDTH)
    ) u_slice (
        .eth_clk  (eth_clk),
        .eth_rst_n(eth_rst_n),
        .s_valid  (fwd_valid),
        .s_ready  (slice_ready),
        .s_data   (s_axis_tdata),
        .s_keep   (s_axis_tkeep),
        .s_last   (s_axis_tlast),
        .m_valid  (m_axis_tvalid),
        .m_ready  (m_axis_tready),
        .m_data   (m_axis_tdata),
        .m_keep   (m_axis_tkeep),
        .m_last   (m_axis_tlast)
    );

endmodule

// File: tb/tb_si_header_parser.sv
// tb_si_header_parser: table-driven directed vectors plus mid-packet reset sequence
module tb_si_header_parser;
    import si_header_pkg::*;

    typedef struct packed {
        logic         v;
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
        logic         mr;
        logic         sr;
        logic         inv;
        logic         mv;
        logic [127:0] md;
        logic [15:0]  mk;
        logic         ml;
        logic         lost;
    } vec_t;

    localparam logic [15:0] F = 16'hFFFF;

    logic         eth_clk = 1'b0;
    logic         eth_rst_n = 1'b0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic [127:0] s_axis_tdata = '0;
    logic [15:0]  s_axis_tkeep = '0;
    logic         s_axis_tlast = 1'b0;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic         m_axis_tlast;
    logic         lost_packet;
    logic         invalid_packet;

    int vectors = 0;
    int miscompares = 0;

    always #5 eth_clk = ~eth_clk;

    si_header_parser dut (
        .eth_clk       (eth_clk),
        .eth_rst_n     (eth_rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .lost_packet   (lost_packet),
        .invalid_packet(invalid_packet)
    );

    function automatic logic [127:0] hdr(input logic [31:0] seq,
                                         input logic [31:0] magic = HDR_MAGIC_DEFAULT,
                                         input logic [7:0]  ver = HDR_VERSION_DEFAULT);
        return {32'h0, seq, 24'h0, ver, magic};
    endfunction

    function automatic logic [127:0] pl(input logic [31:0] n);
        return {4{n}};
    endfunction

    function automatic vec_t row(input logic v, input logic [127:0] d, input logic [15:0] k,
                                 input logic l, input logic mr, input logic sr, input logic inv,
                                 input logic mv, input logic [127:0] md, input logic [15:0] mk,
                                 input logic ml, input logic lost);
        return '{v: v, d: d, k: k, l: l, mr: mr, sr: sr, inv: inv,
                 mv: mv, md: md, mk: mk, ml: ml, lost: lost};
    endfunction

    task automatic apply(input vec_t t, input int tag);
        logic sr_got, inv_got, ok;
        @(negedge eth_clk);
        s_axis_tvalid = t.v;
        s_axis_tdata  = t.d;
        s_axis_tkeep  = t.k;
        s_axis_tlast  = t.l;
        m_axis_tready = t.mr;
        #1;
        sr_got  = s_axis_tready;
        inv_got = invalid_packet;
        ok = sr_got === t.sr && (!t.v || inv_got === t.inv);
        @(posedge eth_clk);
        #1;
        ok = ok && m_axis_tvalid === t.mv && lost_packet === t.lost
             && (!t.mv || (m_axis_tdata === t.md && m_axis_tkeep === t.mk && m_axis_tlast === t.ml));
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL vec[%0d]: got sr=%b inv=%b mv=%b md=%h mk=%h ml=%b lost=%b; want sr=%b inv=%b mv=%b md=%h mk=%h ml=%b lost=%b",
                     tag, sr_got, inv_got, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, lost_packet,
                     t.sr, t.inv, t.mv, t.md, t.mk, t.ml, t.lost);
        end
    endtask

    vec_t tbl [27];

    initial begin
        // good packet seq=5 with a short last beat
        tbl[0]  = row(1, hdr(5),   F, 0, 1,  1, 0,  0, '0, '0, 0, 0);
        tbl[1]  = row(1, pl(1),    F, 0, 1,  1, 0,  1, pl(1), F, 0, 0);
        tbl[2]  = row(1, pl(2),    F, 0, 1,  1, 0,  1, pl(2), F, 0, 0);
        tbl[3]  = row(1, pl(3), 16'h00FF, 1, 1, 1, 0, 1, pl(3), 16'h00FF, 1, 0);
        // seq 6 back-to-back with previous tail, then gap to 9, then 10
        tbl[4]  = row(1, hdr(6),   F, 0, 1,  1, 0,  0, '0, '0, 0, 0);
        tbl[5]  = row(1, pl(4),    F, 1, 1,  1, 0,  1, pl(4), F, 1, 0);
        tbl[6]  = row(1, hdr(9),   F, 0, 1,  1, 0,  0, '0, '0, 0, 1);
        tbl[7]  = row(1, pl(5),    F, 1, 1,  1, 0,  1, pl(5), F, 1, 0);
        tbl[8]  = row(1, hdr(10),  F, 0, 1,  1, 0,  0, '0, '0, 0, 0);
        tbl[9]  = row(1, pl(6),    F, 1, 1,  1, 0,  1, pl(6), F, 1, 0);
        // bad magic packet of 3 beats, stalled output must not block it
        tbl[10] = row(1, hdr(10, 32'hDEADBEEF), F, 0, 1, 1, 1, 0, '0, '0, 0, 0);
        tbl[11] = row(1, pl(7),    F, 0, 0,  1, 1,  0, '0, '0, 0, 0);
        tbl[12] = row(1, pl(8),    F, 1, 0,  1, 1,  0, '0, '0, 0, 0);
        // header-only packet is dropped and leaves expected_seq at 11
        tbl[13] = row(1, hdr(11),  F, 1, 1,  1, 1,  0, '0, '0, 0, 0);
        tbl[14] = row(1, hdr(11),  F, 0, 1,  1, 0,  0, '0, '0, 0, 0);
        tbl[15] = row(1, pl(9),    F, 1, 1,  1, 0,  1, pl(9), F, 1, 0);
        // wrong version, partial keep
        tbl[16] = row(1, hdr(12, HDR_MAGIC_DEFAULT, 8'h02), F, 1, 1, 1, 1, 0, '0, '0, 0, 0);
        tbl[17] = row(1, hdr(12), 16'h7FFF, 1, 1, 1, 1, 0, '0, '0, 0, 0);
        // 0xFFFFFFFF (a gap from 12) then wrap to 0 under toggled m_axis_tready
        tbl[18] = row(1, hdr(32'hFFFF_FFFF), F, 0, 1, 1, 0, 0, '0, '0, 0, 1);
        tbl[19] = row(1, pl(10),   F, 0, 0,  1, 0,  1, pl(10), F, 0, 0);
        tbl[20] = row(1, pl(11),   F, 1, 0,  0, 0,  1, pl(10), F, 0, 0);
        tbl[21] = row(1, pl(11),   F, 1, 1,  1, 0,  1, pl(11), F, 1, 0);
        tbl[22] = row(1, hdr(0),   F, 0, 0,  0, 0,  1, pl(11), F, 1, 0);
        tbl[23] = row(1, hdr(0),   F, 0, 1,  1, 0,  0, '0, '0, 0, 0);
        tbl[24] = row(1, pl(12),   F, 1, 0,  1, 0,  1, pl(12), F, 1, 0);
        tbl[25] = row(0, '0,      '0, 0, 0,  0, 0,  1, pl(12), F, 1, 0);
        tbl[26] = row(0, '0,      '0, 0, 1,  1, 0,  0, '0, '0, 0, 0);

        repeat (3) @(posedge eth_clk);
        #1;
        vectors++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tkeep !== '0
            || m_axis_tlast !== 1'b0 || lost_packet !== 1'b0 || s_axis_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: got mv=%b md=%h mk=%h ml=%b lost=%b sr=%b; want all zero, sr=1",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, lost_packet, s_axis_tready);
        end
        @(negedge eth_clk);
        eth_rst_n = 1'b1;

        for (int i = 0; i < 27; i++) apply(tbl[i], i);

        // reset in the middle of a payload (expected_seq is 1 after the wrap)
        apply(row(1, hdr(1),  F, 0, 1, 1, 0, 0, '0, '0, 0, 0), 100);
        apply(row(1, pl(13),  F, 0, 1, 1, 0, 1, pl(13), F, 0, 0), 101);
        @(negedge eth_clk);
        eth_rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        vectors++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || lost_packet !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got mv=%b md=%h lost=%b; want 0 0 0",
                     m_axis_tvalid, m_axis_tdata, lost_packet);
        end
        repeat (2) @(negedge eth_clk);
        eth_rst_n = 1'b1;
        apply(row(1, pl(14),  F, 0, 1, 1, 1, 0, '0, '0, 0, 0), 102);
        apply(row(1, pl(15),  F, 1, 1, 1, 1, 0, '0, '0, 0, 0), 103);
        apply(row(1, hdr(100), F, 0, 1, 1, 0, 0, '0, '0, 0, 0), 104);
        apply(row(1, pl(16),  F, 1, 1, 1, 0, 1, pl(16), F, 1, 0), 105);
        apply(row(0, '0,     '0, 0, 1, 1, 0, 0, '0, '0, 0, 0), 106);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
